// File: rtl/instruction_loader_pkg.sv
// ----------------------------------------------------------------------------
// instruction_loader_pkg: shared FSM encoding and stream framing constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instruction_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/instruction_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// instruction_loader_word_assembler: packs big-endian bytes into 32-bit words
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] C_LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // The completed word is presented combinationally so the top can register it.
  assign word_valid = byte_valid & ~clear & (idx_q == C_LAST_IDX);
  assign word       = {shift_q, byte_in};

endmodule

`default_nettype wire

// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader: writes a length-prefixed byte stream into instruction RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic [15:0] words_loaded
);

  localparam int          C_HDR_BITS = LEN_BYTES * 8;
  localparam logic [31:0] C_DEPTH    = 32'(IMEM_DEPTH);

  state_e                state_q, state_d;
  logic [C_HDR_BITS-1:0] count_q, count_d;
  logic [C_HDR_BITS-1:0] k_q, k_d;
  logic [15:0]           words_q, words_d;
  logic                  overflow_q, overflow_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  w_accept;
  logic                  w_start_ok;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  logic [C_HDR_BITS-1:0] w_len;

  assign in_ready   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);
  assign w_accept   = in_valid & in_ready;
  assign w_start_ok = start & (state_q == ST_IDLE);
  assign w_len      = {count_q[C_HDR_BITS-9:0], in_byte};

  instruction_loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start_ok),
    .byte_valid (w_accept & (state_q == ST_DATA)),
    .byte_in    (in_byte),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    k_d        = k_q;
    words_d    = words_q;
    overflow_d = overflow_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          count_d    = '0;
          k_d        = '0;
          words_d    = 16'd0;
          overflow_d = 1'b0;
        end
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          count_d = w_len;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          count_d    = w_len;
          overflow_d = 32'(w_len) > C_DEPTH;
          state_d    = (w_len == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid) begin
          k_d = k_q + 1'b1;
          // Words past the RAM are still consumed, but never written or wrapped.
          if (32'(k_q) < C_DEPTH) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + 32'({k_q, 2'b00});
            wdata_d = w_word;
            words_d = words_q + 16'd1;
          end
          if (k_d == count_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      k_q        <= '0;
      words_q    <= 16'd0;
      overflow_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      k_q        <= k_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign overflow     = overflow_q;
  assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_loader.sv
// ----------------------------------------------------------------------------
// tb_instruction_loader: directed scoreboard bench for instruction_loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  // Instance A: default geometry; instance B: tiny RAM at a non-zero base.
  logic        in_ready_a, we_a, hold_a, done_a, ovf_a;
  logic [31:0] addr_a, wdata_a;
  logic [15:0] wl_a;
  logic        in_ready_b, we_b, hold_b, done_b, ovf_b;
  logic [31:0] addr_b, wdata_b;
  logic [15:0] wl_b;

  instruction_loader #(.IMEM_DEPTH(64), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_byte(in_byte), .in_ready(in_ready_a), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .cpu_hold(hold_a), .done(done_a), .overflow(ovf_a),
    .words_loaded(wl_a)
  );

  instruction_loader #(.IMEM_DEPTH(2), .BASE_ADDR(32'h100)) dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
    .in_byte(in_byte), .in_ready(in_ready_b), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .cpu_hold(hold_b), .done(done_b), .overflow(ovf_b),
    .words_loaded(wl_b)
  );

  wire        in_ready     = sel ? in_ready_b : in_ready_a;
  wire        imem_we      = sel ? we_b       : we_a;
  wire [31:0] imem_addr    = sel ? addr_b     : addr_a;
  wire [31:0] imem_wdata   = sel ? wdata_b    : wdata_a;
  wire        cpu_hold     = sel ? hold_b     : hold_a;
  wire        done         = sel ? done_b     : done_a;
  wire        overflow     = sel ? ovf_b      : ovf_a;
  wire [15:0] words_loaded = sel ? wl_b       : wl_a;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("we_addr", imem_addr, e[63:32]);
        chk("we_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("byte_accepted", 32'(got), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send_byte(tmp[7:0], int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // Two-word load
    pulse_start();
    chk("t1_hold_rise", 32'(cpu_hold), 32'd1);
    chk("t1_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({32'h0, 32'h2000_0003});
    exp_q.push_back({32'h4, 32'h2021_0004});
    send_hdr(16'd2);
    chk("t1_hold_mid", 32'(cpu_hold), 32'd1);
    send_word(32'h2000_0003, 0);
    send_word(32'h2021_0004, 0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_last_we", 32'(imem_we), 32'd1);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_hold_done", 32'(cpu_hold), 32'd1);
    tick();
    chk("t1_done_fall", 32'(done), 32'd0);
    chk("t1_hold_fall", 32'(cpu_hold), 32'd0);
    chk("t1_ready_idle", 32'(in_ready), 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty program
    pulse_start();
    send_hdr(16'd0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_we", 32'(imem_we), 32'd0);
    chk("t2_words", 32'(words_loaded), 32'd0);
    chk("t2_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t2_done_fall", 32'(done), 32'd0);
    chk("t2_hold_fall", 32'(cpu_hold), 32'd0);

    // Three words with random input gaps
    pulse_start();
    exp_q.push_back({32'h0, 32'h3C01_1234});
    exp_q.push_back({32'h4, 32'h3421_5678});
    exp_q.push_back({32'h8, 32'hAC01_0000});
    send_byte(8'h00, int'($urandom_range(0, 3)));
    send_byte(8'h03, int'($urandom_range(0, 3)));
    send_word(32'h3C01_1234, 3);
    send_word(32'h3421_5678, 3);
    send_word(32'hAC01_0000, 3);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_words", 32'(words_loaded), 32'd3);
    tick();
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of word 1
    pulse_start();
    exp_q.push_back({32'h0, 32'h8C01_0000});
    send_hdr(16'd2);
    send_word(32'h8C01_0000, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    chk("t5_words_pre", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_hold", 32'(cpu_hold), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    chk("t5_we", 32'(imem_we), 32'd0);
    chk("t5_addr", imem_addr, 32'h0);
    chk("t5_wdata", imem_wdata, 32'h0);
    chk("t5_words", 32'(words_loaded), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    pulse_start();
    exp_q.push_back({32'h0, 32'h0123_4567});
    send_hdr(16'd1);
    send_word(32'h0123_4567, 0);
    chk("t5_reload_done", 32'(done), 32'd1);
    chk("t5_reload_words", 32'(words_loaded), 32'd1);
    tick();
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stray start during DATA is ignored
    pulse_start();
    exp_q.push_back({32'h0, 32'h1111_2222});
    exp_q.push_back({32'h4, 32'h3333_4444});
    send_hdr(16'd2);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    pulse_start();
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h22, 0);
    send_byte(8'h22, 0);
    send_word(32'h3333_4444, 0);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_words", 32'(words_loaded), 32'd2);
    tick();
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // Overflow on the 2-word instance at base 0x100
    sel = 1'b1;
    tick();
    pulse_start();
    exp_q.push_back({32'h100, 32'hCAFE_0001});
    exp_q.push_back({32'h104, 32'hCAFE_0002});
    send_hdr(16'd3);
    chk("t3_ovf_set", 32'(overflow), 32'd1);
    send_word(32'hCAFE_0001, 0);
    pulse_start();
    chk("t3_ovf_kept", 32'(overflow), 32'd1);
    send_word(32'hCAFE_0002, 0);
    send_word(32'hCAFE_0003, 0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_we_supp", 32'(imem_we), 32'd0);
    chk("t3_words", 32'(words_loaded), 32'd2);
    chk("t3_ovf_end", 32'(overflow), 32'd1);
    tick();
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    pulse_start();
    chk("t3_ovf_clear", 32'(overflow), 32'd0);
    exp_q.push_back({32'h100, 32'h2402_0007});
    send_hdr(16'd1);
    chk("t3_ovf_fit", 32'(overflow), 32'd0);
    send_word(32'h2402_0007, 0);
    chk("t3_reload_done", 32'(done), 32'd1);
    tick();
    chk("t3_reload_sb", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
